// File: rtl/fall_scheduler.sv
// fall_scheduler: slot table of falling characters serviced by a one-slot-per-cycle FSM.
// Optional FALL_SCHEDULER_GAMEOVER_EN: the first miss latches gameover and freezes spawn/move/match.
module fall_scheduler #(
  parameter int NSLOT = 16,
  parameter int YW = 10,
  parameter logic [YW-1:0] LOWER_BOUND = 10'd480
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     spawn_req,
  input  logic [7:0]               spawn_ascii,
  input  logic [YW-1:0]            spawn_x,
  input  logic [2:0]               spawn_speed,
  output logic                     spawn_ack,
  output logic                     spawn_drop,
  input  logic                     move_tick,
  input  logic                     key_valid,
  input  logic [7:0]               key_ascii,
  output logic                     hit,
  output logic                     nohit,
  input  logic [$clog2(NSLOT)-1:0] rd_idx,
  output logic                     rd_valid,
  output logic [7:0]               rd_ascii,
  output logic [YW-1:0]            rd_x,
  output logic [YW-1:0]            rd_y,
  output logic [15:0]              score,
  output logic [15:0]              miss_cnt,
  output logic                     busy,
  output logic                     gameover
);
  localparam int IW = $clog2(NSLOT);
  typedef enum logic [2:0] {IDLE, MOVE, MATCH, REMOVE, SPAWN} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d, bi_q, bi_d;
  logic v_q [NSLOT];
  logic v_d [NSLOT];
  logic [7:0] a_q [NSLOT];
  logic [7:0] a_d [NSLOT];
  logic [YW-1:0] x_q [NSLOT];
  logic [YW-1:0] x_d [NSLOT];
  logic [YW-1:0] y_q [NSLOT];
  logic [YW-1:0] y_d [NSLOT];
  logic [2:0] s_q [NSLOT];
  logic [2:0] s_d [NSLOT];
  logic mp_q, mp_d, kp_q, kp_d, fnd_q, fnd_d, go_q, go_d;
  logic [7:0] pk_q, pk_d, mk_q, mk_d;
  logic [YW-1:0] by_q, by_d;
  logic [15:0] score_q, score_d, miss_q, miss_d;
  logic rd_valid_q;
  logic [7:0] rd_ascii_q;
  logic [YW-1:0] rd_x_q, rd_y_q;
  logic [YW:0] ysum;
  logic last;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    v_d = v_q;
    a_d = a_q;
    x_d = x_q;
    y_d = y_q;
    s_d = s_q;
    mp_d = move_tick | mp_q;
    kp_d = key_valid | kp_q;
    pk_d = key_valid ? key_ascii : pk_q;
    mk_d = mk_q;
    fnd_d = fnd_q;
    bi_d = bi_q;
    by_d = by_q;
    score_d = score_q;
    miss_d = miss_q;
    go_d = go_q;
    spawn_ack = 1'b0;
    spawn_drop = 1'b0;
    hit = 1'b0;
    nohit = 1'b0;
    ysum = {1'b0, y_q[idx_q]} + {{(YW-2){1'b0}}, s_q[idx_q]};
    last = idx_q == IW'(NSLOT - 1);
    case (state_q)
      IDLE: begin
        idx_d = '0;
        // a key arriving with a move stays pending and is matched on the next pass
        if (!go_q && (move_tick || mp_q)) begin
          state_d = MOVE;
          mp_d = 1'b0;
        end else if (!go_q && (key_valid || kp_q)) begin
          state_d = MATCH;
          kp_d = 1'b0;
          mk_d = key_valid ? key_ascii : pk_q;
          fnd_d = 1'b0;
        end else if (!go_q && spawn_req) state_d = SPAWN;
      end
      MOVE: begin
        if (v_q[idx_q]) begin
          if (ysum >= {1'b0, LOWER_BOUND}) begin
            v_d[idx_q] = 1'b0;
            miss_d = miss_q + 16'(miss_q != 16'hFFFF);
`ifdef FALL_SCHEDULER_GAMEOVER_EN
            go_d = 1'b1;
`endif
          end else y_d[idx_q] = ysum[YW-1:0];
        end
        idx_d = idx_q + IW'(1);
        state_d = last ? IDLE : MOVE;
      end
      MATCH: begin
        // strict compare on an ascending scan keeps the lowest index on equal rows
        if (v_q[idx_q] && a_q[idx_q] == mk_q && (!fnd_q || y_q[idx_q] > by_q)) begin
          fnd_d = 1'b1;
          bi_d = idx_q;
          by_d = y_q[idx_q];
        end
        idx_d = idx_q + IW'(1);
        state_d = last ? REMOVE : MATCH;
      end
      REMOVE: begin
        if (fnd_q) begin
          v_d[bi_q] = 1'b0;
          score_d = score_q + 16'(score_q != 16'hFFFF);
        end
        hit = fnd_q;
        nohit = !fnd_q;
        state_d = IDLE;
      end
      SPAWN: begin
        if (!v_q[idx_q]) begin
          v_d[idx_q] = 1'b1;
          a_d[idx_q] = spawn_ascii;
          x_d[idx_q] = spawn_x;
          y_d[idx_q] = '0;
          s_d[idx_q] = spawn_speed;
          spawn_ack = 1'b1;
          state_d = IDLE;
        end else begin
          spawn_drop = last;
          state_d = last ? IDLE : SPAWN;
        end
        idx_d = idx_q + IW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      bi_q <= '0;
      v_q <= '{default: 1'b0};
      a_q <= '{default: '0};
      x_q <= '{default: '0};
      y_q <= '{default: '0};
      s_q <= '{default: '0};
      mp_q <= 1'b0;
      kp_q <= 1'b0;
      fnd_q <= 1'b0;
      go_q <= 1'b0;
      pk_q <= '0;
      mk_q <= '0;
      by_q <= '0;
      score_q <= '0;
      miss_q <= '0;
      rd_valid_q <= 1'b0;
      rd_ascii_q <= '0;
      rd_x_q <= '0;
      rd_y_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      bi_q <= bi_d;
      v_q <= v_d;
      a_q <= a_d;
      x_q <= x_d;
      y_q <= y_d;
      s_q <= s_d;
      mp_q <= mp_d;
      kp_q <= kp_d;
      fnd_q <= fnd_d;
      go_q <= go_d;
      pk_q <= pk_d;
      mk_q <= mk_d;
      by_q <= by_d;
      score_q <= score_d;
      miss_q <= miss_d;
      rd_valid_q <= v_q[rd_idx];
      rd_ascii_q <= a_q[rd_idx];
      rd_x_q <= x_q[rd_idx];
      rd_y_q <= y_q[rd_idx];
    end
  end
  assign rd_valid = rd_valid_q;
  assign rd_ascii = rd_ascii_q;
  assign rd_x = rd_x_q;
  assign rd_y = rd_y_q;
  assign score = score_q;
  assign miss_cnt = miss_q;
  assign busy = state_q != IDLE;
  assign gameover = go_q;
endmodule
